// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing the dm_cache_fsm CPU request port between N_REQ requesters.
// Define CACHE_ARB_PERF_EN to add per-requester completion and wait counters.
module cache_req_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_rw_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
    output logic [N_REQ-1:0]        req_done_o,
    output logic [DATA_W-1:0]       req_rdata_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    cache_valid_o,
    output logic                    cache_rw_o,
    output logic [ADDR_W-1:0]       cache_addr_o,
    output logic [DATA_W-1:0]       cache_wdata_o,
    input  logic                    cache_ready_i,
    input  logic [DATA_W-1:0]       cache_rdata_i
`ifdef CACHE_ARB_PERF_EN
    ,
    output logic [N_REQ*16-1:0]     perf_grants_o,
    output logic [N_REQ*16-1:0]     perf_wait_o
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ISSUE,
        RELEASE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   pick;
    logic [N_REQ-1:0]   pick_oh;
    logic [N_REQ-1:0]   rot;
    logic               any_req;
    logic               sel_rw;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // Rotate the request vector so bit 0 is the rr pointer; lowest set bit wins.
    always_comb begin
        pick      = '0;
        any_req   = 1'b0;
        pick_oh   = '0;
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        rot       = N_REQ'({req_valid_i, req_valid_i} >> rr);
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any_req = 1'b1;
                pick    = IDX_W'((int'(rr) + i) % N_REQ);
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (pick == IDX_W'(k)) begin
                pick_oh[k] = 1'b1;
                sel_rw     = req_rw_i[k];
                sel_addr   = req_addr_i[k*ADDR_W +: ADDR_W];
                sel_wdata  = req_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state         <= IDLE;
            rr            <= '0;
            owner         <= '0;
            grant_o       <= '0;
            req_done_o    <= '0;
            req_rdata_o   <= '0;
            cache_valid_o <= 1'b0;
            cache_rw_o    <= 1'b0;
            cache_addr_o  <= '0;
            cache_wdata_o <= '0;
        end else begin
            req_done_o <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner         <= pick;
                        grant_o       <= pick_oh;
                        cache_rw_o    <= sel_rw;
                        cache_addr_o  <= sel_addr;
                        cache_wdata_o <= sel_wdata;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    cache_valid_o <= 1'b1;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    if (cache_ready_i) begin
                        req_rdata_o   <= cache_rdata_i;
                        req_done_o    <= grant_o;
                        rr            <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
                        grant_o       <= '0;
                        cache_valid_o <= 1'b0;
                        cache_rw_o    <= 1'b0;
                        state         <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_ARB_PERF_EN
    // Saturating 16-bit counters; completions counted on the accepting edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            perf_grants_o <= '0;
            perf_wait_o   <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (state == ISSUE && cache_ready_i && grant_o[k]
                    && perf_grants_o[k*16 +: 16] != 16'hFFFF) begin
                    perf_grants_o[k*16 +: 16] <= perf_grants_o[k*16 +: 16] + 16'd1;
                end
                if (req_valid_i[k] && !grant_o[k]
                    && perf_wait_o[k*16 +: 16] != 16'hFFFF) begin
                    perf_wait_o[k*16 +: 16] <= perf_wait_o[k*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
